// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
// Counts rising edges of an asynchronous, slower signal MON_IN over a fixed
// gate window of CLK cycles. It reports each completed window with a
// one-cycle VALID strobe and flags counts outside [MIN_COUNT, MAX_COUNT].
// A separate watchdog raises LOS when no edge has been seen for LOS_CYCLES
// cycles.
module clk_freq_monitor #(
  parameter int unsigned GATE_CYCLES = 27000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MIN_COUNT   = 0,
  parameter int unsigned MAX_COUNT   = 65535,
  parameter int unsigned LOS_CYCLES  = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             MON_IN,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             LOW,
  output logic             HIGH,
  output logic             LOS
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned LOS_W  = $clog2(LOS_CYCLES + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [LOS_W-1:0]  LOS_MAX   = LOS_W'(LOS_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Thresholds widened to 33 signed bits so that the range checks work for
  // any parameter value, including MIN_COUNT = 0 and MAX_COUNT >= 2**CNT_W.
  localparam logic signed [32:0] MIN_S = {1'b0, MIN_COUNT};
  localparam logic signed [32:0] MAX_S = {1'b0, MAX_COUNT};

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Adds a single edge to a count and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic             inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{CNT_W{1'b0}}, inc};
    sat_add = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // True when a count falls below the lowest in-range value.
  function automatic logic below_min(input logic [CNT_W-1:0] value);
    logic signed [32:0] wide;
    wide = $signed({1'b0, 32'(value)});
    below_min = (wide < MIN_S);
  endfunction

  // True when a count exceeds the highest in-range value.
  function automatic logic above_max(input logic [CNT_W-1:0] value);
    logic signed [32:0] wide;
    wide = $signed({1'b0, 32'(value)});
    above_max = (wide > MAX_S);
  endfunction

  state_t            state;
  state_t            state_next;
  logic              counting;
  logic              win_end;

  logic              mon_p0;
  logic              mon_p1;
  logic              mon_p2;
  logic              rise;

  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  win_total;

  logic [LOS_W-1:0]  los_cnt;
  logic [LOS_W-1:0]  los_next;

  logic [CNT_W-1:0]  count_p3;
  logic              vld_p3;
  logic              low_p3;
  logic              high_p3;
  logic              los_p3;

  // ---- stage p0..p2: two-flop synchronizer plus edge-detect register ----
  // Cleared on reset, so a MON_IN that is already high at release is seen
  // as one fresh rising edge once it has passed through the synchronizer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mon_p0 <= 1'b0;
      mon_p1 <= 1'b0;
      mon_p2 <= 1'b0;
    end else begin
      mon_p0 <= MON_IN;
      mon_p1 <= mon_p0;
      mon_p2 <= mon_p1;
    end
  end

  assign rise = mon_p1 & ~mon_p2;

  // Holds the measurement state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Chooses the next state and marks window completion and abort. The final
  // cycle of a window always completes; EN only decides whether the next
  // window starts immediately or the monitor returns to IDLE.
  always_comb begin
    state_next = state;
    counting   = 1'b0;
    win_end    = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (gate_cnt == GATE_LAST) begin
          win_end = 1'b1;
          if (!EN) begin
            state_next = IDLE;
          end
        end else if (EN) begin
          counting = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gate and edge counters: advance while a window is open, clear on window
  // end, on abort and in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (counting) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      edge_cnt <= sat_add(edge_cnt, rise);
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end
  end

  // An edge landing in the last cycle of the window still belongs to it.
  assign win_total = sat_add(edge_cnt, rise);

  // ---- stage p3: result registers, updated together with VALID ----
  // COUNT, LOW and HIGH hold between windows and across an abort.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_p3 <= '0;
      vld_p3   <= 1'b0;
      low_p3   <= 1'b0;
      high_p3  <= 1'b0;
    end else begin
      vld_p3 <= win_end;
      if (win_end) begin
        count_p3 <= win_total;
        low_p3   <= below_min(win_total);
        high_p3  <= above_max(win_total);
      end
    end
  end

  // Loss-of-signal counter runs regardless of EN; an edge in the cycle the
  // threshold would be reached takes priority and keeps LOS low.
  always_comb begin
    los_next = los_cnt;
    if (rise) begin
      los_next = '0;
    end else if (los_cnt != LOS_MAX) begin
      los_next = los_cnt + LOS_W'(1);
    end
  end

  // Registers the LOS counter and its threshold flag side by side.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      los_cnt <= '0;
      los_p3  <= 1'b0;
    end else begin
      los_cnt <= los_next;
      los_p3  <= (los_next == LOS_MAX);
    end
  end

  assign COUNT = count_p3;
  assign VALID = vld_p3;
  assign LOW   = low_p3;
  assign HIGH  = high_p3;
  assign LOS   = los_p3;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Testbench for clk_freq_monitor. Two instances share the stimulus: one with
// an 8-bit count and a narrow in-range band, one with a 4-bit count to
// exercise saturation. A reference model records MON_IN as sampled on every
// clock and derives each window's count from the list of detected edges.
module tb_clk_freq_monitor;

  localparam int G    = 100;
  localparam int L    = 32;
  localparam int MAXC = 20000;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       EN;
  logic       MON_IN;

  logic [7:0] count_a;
  logic       valid_a, low_a, high_a, los_a;
  logic [3:0] count_b;
  logic       valid_b, low_b, high_b, los_b;

  clk_freq_monitor #(
    .GATE_CYCLES(G), .CNT_W(8), .MIN_COUNT(8), .MAX_COUNT(12), .LOS_CYCLES(L)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MON_IN(MON_IN),
    .COUNT(count_a), .VALID(valid_a), .LOW(low_a), .HIGH(high_a), .LOS(los_a)
  );

  clk_freq_monitor #(
    .GATE_CYCLES(G), .CNT_W(4), .MIN_COUNT(0), .MAX_COUNT(10), .LOS_CYCLES(L)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MON_IN(MON_IN),
    .COUNT(count_b), .VALID(valid_b), .LOW(low_b), .HIGH(high_b), .LOS(los_b)
  );

  always #5 CLK = ~CLK;

  int total;
  int bad;

  // reference model state
  int n;
  int base;
  int last;
  bit hist [MAXC];
  bit edg  [MAXC];
  bit in_win;
  int start;
  int exp_cnt_a, exp_cnt_b;
  int exp_valid, exp_low_a, exp_high_a, exp_low_b, exp_high_b, exp_los;

  // MON_IN generator: 0 manual, 1 periodic, 2 random phase lengths
  int gen_mode;
  int gen_p;
  int gen_ph;
  int gen_left;

  typedef struct {
    int period;
    int lo_a;
    int hi_a;
    int low_a;
    int high_a;
    int lo_b;
    int hi_b;
    int high_b;   // 2 = not checked (count sits on the threshold)
  } row_t;

  row_t rows [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, n);
    end
  endtask

  function automatic bit hist_at(input int i);
    if (i < base || i < 0) return 1'b0;
    return hist[i];
  endfunction

  task automatic model_reset();
    base       = n + 1;
    last       = n;
    in_win     = 1'b0;
    start      = 0;
    exp_cnt_a  = 0;
    exp_cnt_b  = 0;
    exp_valid  = 0;
    exp_low_a  = 0;
    exp_high_a = 0;
    exp_low_b  = 0;
    exp_high_b = 0;
    exp_los    = 0;
  endtask

  // One active clock edge n with EN and MON_IN as sampled there. A rise
  // sampled first at edge k is counted at edge k+2. A window opened by EN
  // seen at edge s covers the edges counted at s+1 .. s+G.
  task automatic model_step(input bit en_s, input bit mon_s);
    bit e;
    int raw;
    hist[n] = mon_s;
    e = hist_at(n - 2) && !hist_at(n - 3);
    edg[n] = e;
    if (e) last = n;
    exp_valid = 0;
    if (!in_win) begin
      if (en_s) begin
        in_win = 1'b1;
        start  = n;
      end
    end else if (n - start == G) begin
      raw = 0;
      for (int i = start + 1; i <= n; i++) raw += int'(edg[i]);
      exp_cnt_a  = (raw > 255) ? 255 : raw;
      exp_cnt_b  = (raw > 15) ? 15 : raw;
      exp_low_a  = int'(exp_cnt_a < 8);
      exp_high_a = int'(exp_cnt_a > 12);
      exp_low_b  = 0;
      exp_high_b = int'(exp_cnt_b > 10);
      exp_valid  = 1;
      if (en_s) start = n;
      else      in_win = 1'b0;
    end else if (!en_s) begin
      in_win = 1'b0;
    end
    exp_los = int'(!e && (n - last >= L));
  endtask

  task automatic check_all();
    chk("count_a", int'(count_a), exp_cnt_a);
    chk("valid_a", int'(valid_a), exp_valid);
    chk("low_a",   int'(low_a),   exp_low_a);
    chk("high_a",  int'(high_a),  exp_high_a);
    chk("los_a",   int'(los_a),   exp_los);
    chk("count_b", int'(count_b), exp_cnt_b);
    chk("valid_b", int'(valid_b), exp_valid);
    chk("low_b",   int'(low_b),   exp_low_b);
    chk("high_b",  int'(high_b),  exp_high_b);
    chk("los_b",   int'(los_b),   exp_los);
  endtask

  task automatic gen_start(input int p);
    gen_mode = 1;
    gen_p    = p;
    gen_ph   = 0;
    MON_IN   = 1'b1;
  endtask

  task automatic gen_next();
    case (gen_mode)
      1: begin
        gen_ph = (gen_ph + 1) % gen_p;
        MON_IN = (gen_ph < gen_p / 2);
      end
      2: begin
        gen_left--;
        if (gen_left <= 0) begin
          MON_IN   = ~MON_IN;
          gen_left = int'($urandom_range(2, 9));
        end
      end
      default: ;
    endcase
  endtask

  // Advance one clock: sample just after the edge, update model, compare,
  // then drive the next MON_IN value.
  task automatic tick();
    @(posedge CLK);
    #1;
    n++;
    if (n >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", n, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (RESET) model_reset();
    else       model_step(EN, MON_IN);
    check_all();
    gen_next();
  endtask

  // Clocks until dut_a strobes VALID; k is the number of clocks, -1 on timeout.
  task automatic wait_valid(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (valid_a) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    int r;
    int q;
    int los_at;
    int seen;

    rows[0] = '{10,  9, 11, 0, 0,  9, 11, 2};
    rows[1] = '{20,  4,  6, 1, 0,  4,  6, 0};
    rows[2] = '{5,  19, 21, 0, 1, 15, 15, 1};
    rows[3] = '{4,  24, 26, 0, 1, 15, 15, 1};

    total    = 0;
    bad      = 0;
    n        = 0;
    gen_mode = 0;
    gen_p    = 1;
    gen_ph   = 0;
    gen_left = 0;
    RESET    = 1'b1;
    EN       = 1'b0;
    MON_IN   = 1'b0;
    model_reset();

    // reset state, then release between clock edges
    repeat (3) tick();
    #2 RESET = 1'b0;
    repeat (5) tick();

    // table: periodic input, three windows each, fresh start per row
    for (int i = 0; i < 4; i++) begin
      EN = 1'b0;
      repeat (3) tick();
      gen_start(rows[i].period);
      EN = 1'b1;
      for (int w = 0; w < 3; w++) begin
        wait_valid(G + 50, k);
        chk("tbl_spacing", k, (w == 0) ? G + 1 : G);
        chk_range("tbl_count_a", int'(count_a), rows[i].lo_a, rows[i].hi_a);
        chk("tbl_low_a",  int'(low_a),  rows[i].low_a);
        chk("tbl_high_a", int'(high_a), rows[i].high_a);
        chk_range("tbl_count_b", int'(count_b), rows[i].lo_b, rows[i].hi_b);
        if (rows[i].high_b != 2) chk("tbl_high_b", int'(high_b), rows[i].high_b);
      end
    end

    // abort mid-window: no VALID, results hold, re-enable gives a full window
    EN = 1'b0;
    repeat (3) tick();
    gen_start(10);
    EN = 1'b1;
    wait_valid(G + 50, k);
    chk("abort_pre", k, G + 1);
    repeat (50) tick();
    EN = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (valid_a || valid_b) seen = 1;
    end
    chk("abort_no_valid", seen, 0);
    chk_range("abort_hold_a", int'(count_a), 9, 11);
    EN = 1'b1;
    wait_valid(G + 50, k);
    chk("abort_fresh", k, G + 1);
    chk_range("abort_count_a", int'(count_a), 9, 11);

    // loss of signal: one isolated rise, then starvation
    gen_mode = 0;
    MON_IN   = 1'b0;
    repeat (20) tick();
    r = n;
    MON_IN = 1'b1;
    repeat (2) tick();
    MON_IN = 1'b0;
    los_at = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (los_a) begin
        los_at = n;
        break;
      end
    end
    chk("los_assert_delay", los_at - (r + 3), L);
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (valid_a && count_a == 8'd0) seen = 1;
    end
    chk("starved_zero", seen, 1);
    q = n;
    MON_IN = 1'b1;
    repeat (2) tick();
    chk("los_hold", int'(los_a), 1);
    tick();
    chk("los_clear", int'(los_a), 0);
    chk("los_clear_cycle", n - q, 3);

    // randomized phase lengths with occasional EN toggles
    gen_mode = 2;
    gen_left = 3;
    EN = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) EN = ~EN;
    end

    // asynchronous reset mid-window
    gen_start(10);
    EN = 1'b1;
    wait_valid(2 * G + 50, k);
    chk_range("rst_pre_count", int'(count_a), 9, 11);
    repeat (40) tick();
    #3 RESET = 1'b1;
    #1;
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_low_a",   int'(low_a),   0);
    chk("rst_high_a",  int'(high_a),  0);
    chk("rst_los_a",   int'(los_a),   0);
    chk("rst_count_b", int'(count_b), 0);
    chk("rst_los_b",   int'(los_b),   0);
    model_reset();
    repeat (3) tick();
    #2 RESET = 1'b0;
    wait_valid(G + 50, k);
    chk("rst_first_valid", k, G + 1);
    chk_range("rst_count_a_after", int'(count_a), 9, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
